// File: rtl/dcache_pkg.sv
// Geometry, state encoding and address-field helpers for the direct-mapped data cache.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dcache_pkg;

  // Cache geometry lives here so every file slices addresses the same way.
  localparam int ADDR_W         = 32;
  localparam int NUM_LINES      = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE * 4);
  localparam int IDX_W          = $clog2(NUM_LINES);
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W;
  localparam int WOFF_W         = $clog2(WORDS_PER_LINE);
  localparam int LINE_W         = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RETRY} dcache_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (OFF_W + IDX_W));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> OFF_W);
  endfunction

  // Word offset within the line; byte bits [1:0] are dropped (word access only).
  function automatic logic [WOFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
    return WOFF_W'(addr >> 2);
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag/valid/dirty/data arrays of the data cache: one comb read port, one word write, one line fill.
// Latency: reads combinational; writes and fills visible after the next rising edge.
// Backpressure: none; fill has priority over the word write, reset invalidates every line.
// Ports: clk/reset; rd_* read port (index in, tag/valid/dirty/line out); wr_* word store;
//        fill_* whole-line install (sets valid, clears dirty).
module dcache_store
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_off,
  input  logic [31:0]       wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Only the status bits are reset; tags and data are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_line;
    end else if (wr_en) begin
      data_q[wr_idx][32*wr_off +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: hit logic, miss FSM, memory-side registers.
// Latency: hits 0 cycles; miss releases after 2 + writeback wait + refill wait cycles.
// Backpressure: cpu_stall held high from the miss cycle until the retried access hits.
// Ports: cpu_* core data port (read/write/addr/wdata in, rdata/stall out);
//        mem_* line-wide memory port (req/we/addr/wdata out, rdata/ready in).
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  dcache_state_t      state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic               mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_d;

  logic [TAG_W-1:0]   cpu_tag, rd_tag;
  logic [IDX_W-1:0]   cpu_idx;
  logic [WOFF_W-1:0]  cpu_off;
  logic               rd_valid, rd_dirty, req, hit, wr_en, fill_en;
  logic [LINE_W-1:0]  rd_line;
  logic [31:0]        hit_word;

  assign cpu_tag  = addr_tag(cpu_addr);
  assign cpu_idx  = addr_idx(cpu_addr);
  assign cpu_off  = addr_off(cpu_addr);
  assign req      = cpu_read | cpu_write;
  assign hit      = rd_valid && (rd_tag == cpu_tag);
  assign hit_word = rd_line[32*cpu_off +: 32];

  // The missing tag/index are latched so refill and install do not depend on
  // the core keeping its request stable while stalled.
  dcache_store u_store (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (cpu_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_idx    (cpu_idx),
    .wr_off    (cpu_off),
    .wr_data   (cpu_wdata),
    .fill_en   (fill_en),
    .fill_idx  (miss_idx_q),
    .fill_tag  (miss_tag_q),
    .fill_line (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

  // Memory-side outputs are loaded one edge ahead of the state they belong to,
  // so they are registered and stable for the whole transaction.
  always_comb begin
    state_d     = state_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wr_en       = 1'b0;
    fill_en     = 1'b0;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (cpu_write) wr_en = 1'b1;   // write wins over a simultaneous read
          else           cpu_rdata = hit_word;
        end else if (req) begin
          cpu_stall  = 1'b1;
          miss_tag_d = cpu_tag;
          miss_idx_d = cpu_idx;
          mem_req_d  = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d     = WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = line_addr(rd_tag, cpu_idx);
            mem_wdata_d = rd_line;
          end else begin
            state_d     = ALLOCATE;
            mem_we_d    = 1'b0;
            mem_addr_d  = line_addr(cpu_tag, cpu_idx);
            mem_wdata_d = '0;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall = 1'b1;
        if (mem_ready) begin
          state_d     = ALLOCATE;
          mem_we_d    = 1'b0;
          mem_addr_d  = line_addr(miss_tag_q, miss_idx_q);
          mem_wdata_d = '0;
        end
      end
      ALLOCATE: begin
        cpu_stall = 1'b1;
        if (mem_ready) begin
          fill_en     = 1'b1;
          state_d     = RETRY;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      RETRY: begin
        // Gives the freshly installed line one edge to appear on the read port.
        cpu_stall = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: transaction-level cache/memory model, per-cycle compare.
// Latency: n/a.
// Backpressure: bench acts as core and memory, answering memory requests after 0-3 wait cycles.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall, mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cache contents per line plus a sparse backing memory keyed by line address.
  logic [127:0] m_data  [16];
  logic [23:0]  m_tag   [16];
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [127:0] mem [logic [31:0]];

  // Expected outputs for the current cycle.
  bit           e_chk = 1'b0;
  logic         e_stall, e_mreq, e_mwe;
  bit           e_rchk;
  logic [31:0]  e_rdata, e_maddr;
  logic [127:0] e_mwdata;

  // Record of the last modelled access.
  bit           last_hit, last_wb;
  logic [31:0]  last_wb_addr, last_al_addr, last_rdata;
  logic [127:0] last_wb_line;
  int           fixed_dly = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_chk) begin
      check("cpu_stall", 128'(cpu_stall), 128'(e_stall));
      if (e_rchk) check("cpu_rdata", 128'(cpu_rdata), 128'(e_rdata));
      check("mem_req",   128'(mem_req),   128'(e_mreq));
      check("mem_we",    128'(mem_we),    128'(e_mwe));
      check("mem_addr",  128'(mem_addr),  128'(e_maddr));
      check("mem_wdata", mem_wdata,       e_mwdata);
    end
  end

  task automatic set_exp(input logic stall, input bit rchk, input logic [31:0] rdata,
                         input logic mreq, input logic mwe, input logic [31:0] maddr,
                         input logic [127:0] mwdata);
    e_stall = stall; e_rchk = rchk; e_rdata = rdata;
    e_mreq = mreq; e_mwe = mwe; e_maddr = maddr; e_mwdata = mwdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dly();
    return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
  endfunction

  // One core access from request to release, acting as memory on a miss.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit drop, input bit abort);
    int idx, off, d;
    logic [23:0] tag;
    idx = int'((addr >> 4) & 32'hF);
    off = int'((addr >> 2) & 32'h3);
    tag = addr[31:8];
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata; mem_ready = 1'b0;
    last_hit = m_valid[idx] && (m_tag[idx] == tag);
    last_wb  = 1'b0;
    if (!last_hit) begin
      set_exp(1, 0, 0, 0, 0, 0, '0);
      step();
      if (m_valid[idx] && m_dirty[idx]) begin
        last_wb      = 1'b1;
        last_wb_addr = {m_tag[idx], 4'(idx), 4'h0};
        last_wb_line = m_data[idx];
        set_exp(1, 0, 0, 1, 1, last_wb_addr, last_wb_line);
        d = dly();
        repeat (d) step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem[last_wb_addr] = last_wb_line;
      end
      last_al_addr = {tag, 4'(idx), 4'h0};
      if (!mem.exists(last_al_addr))
        mem[last_al_addr] = {$urandom, $urandom, $urandom, $urandom};
      set_exp(1, 0, 0, 1, 0, last_al_addr, '0);
      if (drop) begin
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = $urandom;
      end
      d = dly();
      repeat (d) step();
      if (abort) begin
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
        set_exp(0, 1, 0, 0, 0, 0, '0);
        step();
        return;
      end
      mem_rdata = mem[last_al_addr];
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      m_data[idx] = mem[last_al_addr]; m_tag[idx] = tag;
      m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
      set_exp(1, 0, 0, 0, 0, 0, '0);
      step();
      if (drop) begin
        set_exp(0, 1, 0, 0, 0, 0, '0);
        step();
        return;
      end
    end
    if (wr) begin
      set_exp(0, rd, 0, 0, 0, 0, '0);
      m_data[idx][off*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end else begin
      last_rdata = m_data[idx][off*32 +: 32];
      set_exp(0, 1, last_rdata, 0, 0, 0, '0);
    end
    step();
    cpu_read = 1'b0; cpu_write = 1'b0;
    set_exp(0, 1, 0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [23:0] t;
    logic [31:0] a;
    int k;
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    mem[32'h40] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    e_chk = 1'b1;
    set_exp(0, 1, 0, 0, 0, 0, '0);
    step();

    fixed_dly = 3;
    access(1, 0, 32'h40, 0, 0, 0);
    check("pin_cold_alloc_addr", 128'(last_al_addr), 128'h40);
    check("pin_cold_rdata", 128'(last_rdata), 128'hDEADBEEF);
    fixed_dly = 1;
    access(1, 0, 32'h44, 0, 0, 0);
    check("pin_hit_flag", 128'(last_hit), 128'd1);
    check("pin_word1", 128'(last_rdata), 128'h11111111);
    access(0, 1, 32'h48, 32'h12345678, 0, 0);
    access(1, 0, 32'h48, 0, 0, 0);
    check("pin_store_read", 128'(last_rdata), 128'h12345678);
    access(1, 0, 32'h140, 0, 0, 0);
    check("pin_wb_flag", 128'(last_wb), 128'd1);
    check("pin_wb_addr", 128'(last_wb_addr), 128'h40);
    check("pin_wb_word2", 128'(last_wb_line[95:64]), 128'h12345678);
    check("pin_conflict_alloc", 128'(last_al_addr), 128'h140);
    access(0, 1, 32'h80, 32'hCAFEF00D, 0, 0);
    check("pin_clean_no_wb", 128'(last_wb), 128'd0);
    check("pin_merge_dirty", 128'(m_dirty[8]), 128'd1);
    access(1, 0, 32'h240, 0, 0, 1);
    access(1, 0, 32'h140, 0, 0, 0);
    check("pin_post_reset_miss", 128'(last_hit), 128'd0);
    check("pin_post_reset_no_wb", 128'(last_wb), 128'd0);

    fixed_dly = -1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: t = 24'h000000;
        1: t = 24'h000001;
        2: t = 24'h000002;
        3: t = 24'h000ABC;
        default: t = 24'hFFFFFF;
      endcase
      a = {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      k = int'($urandom_range(0, 9));
      access(k <= 4 || k == 9, k >= 5, a, $urandom,
             $urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) step();
    end

    e_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
